// File: rtl/main_2_pkg.sv
// Shared constants and types for the main_2 BLDC commutation block.
// Hall codes, sector gate vectors and the sector decoder live here.
package main_2_pkg;

   typedef struct packed {
      logic [2:0] hi;
      logic [2:0] lo;
   } gate_t;

   localparam logic [2:0] HALL_S1 = 3'b101;
   localparam logic [2:0] HALL_S2 = 3'b100;
   localparam logic [2:0] HALL_S3 = 3'b110;
   localparam logic [2:0] HALL_S4 = 3'b010;
   localparam logic [2:0] HALL_S5 = 3'b011;
   localparam logic [2:0] HALL_S6 = 3'b001;
   localparam logic [2:0] HALL_NONE = 3'b000;
   localparam logic [2:0] HALL_ALL = 3'b111;

   // hi = {A,B,C}, lo = {AA,BB,CC}
   localparam gate_t G_S1 = gate_t'(6'b100_010);
   localparam gate_t G_S2 = gate_t'(6'b100_001);
   localparam gate_t G_S3 = gate_t'(6'b010_001);
   localparam gate_t G_S4 = gate_t'(6'b010_100);
   localparam gate_t G_S5 = gate_t'(6'b001_100);
   localparam gate_t G_S6 = gate_t'(6'b001_010);
   localparam gate_t G_OFF = gate_t'(6'b000_000);

   function automatic gate_t hall_decode(
      input logic [2:0] h
   );
      gate_t g;
      unique case (1'b1)
         (h == HALL_S1): g = G_S1;
         (h == HALL_S2): g = G_S2;
         (h == HALL_S3): g = G_S3;
         (h == HALL_S4): g = G_S4;
         (h == HALL_S5): g = G_S5;
         (h == HALL_S6): g = G_S6;
         default:        g = G_OFF;
      endcase
      return g;
   endfunction

   function automatic logic hall_valid(
      input logic [2:0] h
   );
      return (h != HALL_NONE) && (h != HALL_ALL);
   endfunction

endpackage

// File: rtl/main_2_pwm.sv
// PWM generator: free-running counter, duty latched at period end,
// enable high while counter is below the latched duty.
module main_2_pwm
   import main_2_pkg::*;
#(
   parameter int PWM_BITS = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [PWM_BITS-1:0] i_w,
   output logic                o_en
);

   logic [PWM_BITS-1:0] r_cnt;
   logic [PWM_BITS-1:0] r_wq;
   logic                w_last;

   assign w_last = (r_cnt == {PWM_BITS{1'b1}});

   // Counter wraps naturally; duty only updates on the last count.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
         r_wq  <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
         if (w_last) r_wq <= i_w;
      end
   end

   assign o_en = (r_cnt < r_wq);

endmodule

// File: rtl/main_2.sv
// Six-step BLDC commutation: Hall sync, sector decode, dead time,
// high-side PWM gating and registered gate outputs.
module main_2
   import main_2_pkg::*;
#(
   parameter int PWM_BITS    = 4,
   parameter int DEAD_CYCLES = 2
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                H1,
   input  logic                H2,
   input  logic                H3,
   input  logic [PWM_BITS-1:0] W,
   output logic                A,
   output logic                AA,
   output logic                B,
   output logic                BB,
   output logic                C,
   output logic                CC
);

   localparam int DW =
      (DEAD_CYCLES < 1) ? 1 : $clog2(DEAD_CYCLES + 1);
   localparam logic [DW-1:0] DEAD_LD = DW'(DEAD_CYCLES);

   logic [2:0]    r_sync1;
   logic [2:0]    r_sync2;
   logic [2:0]    r_prev;
   logic [DW-1:0] r_dead;
   gate_t         r_gate;

   logic [2:0]    w_hall;
   logic          w_change;
   logic          w_pwm_en;
   logic [DW-1:0] w_dead_nxt;
   gate_t         w_sel;
   gate_t         w_gate_nxt;

   main_2_pwm #(
      .PWM_BITS (PWM_BITS)
   ) u_pwm (
      .i_clk   (CLK),
      .i_rst_n (RST_N),
      .i_w     (W),
      .o_en    (w_pwm_en)
   );

   // Two-flop synchronizer on the raw Hall lines.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= {H3, H2, H1};
         r_sync2 <= r_sync1;
      end
   end

   assign w_hall   = r_sync2;
   assign w_change = (w_hall != r_prev);

   // Dead counter reloads on any Hall change, else counts down.
   always_comb begin
      w_dead_nxt = '0;
      if (w_change) begin
         w_dead_nxt = DEAD_LD;
      end else if (r_dead != '0) begin
         w_dead_nxt = r_dead - DW'(1);
      end
   end

   // Next gate vector: off during dead time or invalid code.
   always_comb begin
      w_gate_nxt = G_OFF;
      w_sel      = hall_decode(w_hall);
      if (hall_valid(w_hall) && (w_dead_nxt == '0)) begin
         w_gate_nxt.hi = w_sel.hi & {3{w_pwm_en}};
         w_gate_nxt.lo = w_sel.lo;
      end
   end

   // Previous Hall, dead counter and registered gates.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_prev <= '0;
         r_dead <= '0;
         r_gate <= G_OFF;
      end else begin
         r_prev <= w_hall;
         r_dead <= w_dead_nxt;
         r_gate <= w_gate_nxt;
      end
   end

   assign {A, B, C}    = r_gate.hi;
   assign {AA, BB, CC} = r_gate.lo;

endmodule

// File: tb/tb_main_2.sv
// Directed bench for main_2: reset, rotation, dead-time reload,
// invalid codes, duty boundaries, async reset, gate invariant.
module tb_main_2;

   localparam int DC = 2;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       H1 = 1'b0;
   logic       H2 = 1'b0;
   logic       H3 = 1'b0;
   logic [3:0] W = 4'd0;
   logic       A, AA, B, BB, C, CC;

   int total = 0;
   int bad = 0;
   int tb_cnt = 0;

   main_2 #(
      .PWM_BITS    (4),
      .DEAD_CYCLES (DC)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .H1    (H1),
      .H2    (H2),
      .H3    (H3),
      .W     (W),
      .A     (A),
      .AA    (AA),
      .B     (B),
      .BB    (BB),
      .C     (C),
      .CC    (CC)
   );

   always #10 CLK = ~CLK;

   // Reference PWM counter phase (value after each edge).
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) tb_cnt <= 0;
      else        tb_cnt <= (tb_cnt + 1) % 16;
   end

   // Gate safety invariant, checked every cycle out of reset.
   always @(negedge CLK) begin
      if (RST_N) begin
         total++;
         if ((A & AA) || (B & BB) || (C & CC) ||
             ($countones({A, B, C}) > 1) ||
             ($countones({AA, BB, CC}) > 1)) begin
            bad++;
            $display("FAIL invariant t=%0t got=%b", $time,
                     {A, B, C, AA, BB, CC});
         end
      end
   end

   function automatic logic [5:0] outs();
      return {A, B, C, AA, BB, CC};
   endfunction

   // {A,B,C,AA,BB,CC} for each Hall code.
   function automatic logic [5:0] exp_vec(input logic [2:0] h);
      case (h)
         3'b101:  return 6'b100_010;
         3'b100:  return 6'b100_001;
         3'b110:  return 6'b010_001;
         3'b010:  return 6'b010_100;
         3'b011:  return 6'b001_100;
         3'b001:  return 6'b001_010;
         default: return 6'b000_000;
      endcase
   endfunction

   task automatic set_hall(input logic [2:0] h);
      {H3, H2, H1} = h;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      int hi;
      logic [5:0] o;
      hi = 0;
      RST_N = 1'b0;
      set_hall(3'b101);
      W = 4'd8;
      repeat (3) @(negedge CLK);
      total++;
      if (outs() !== 6'b0) begin
         bad++;
         $display("FAIL reset_outs got=%b want=000000", outs());
      end
      @(negedge CLK);
      RST_N = 1'b1;
      for (int e = 1; e <= 32; e++) begin
         tick();
         o = outs();
         if (e <= 2 + DC) begin
            total++;
            if (o !== 6'b0) begin
               bad++;
               $display("FAIL reset_predrive e=%0d got=%b want=0",
                        e, o);
            end
         end
         if (e == 3 + DC) begin
            total++;
            if (o !== 6'b000_010) begin
               bad++;
               $display("FAIL first_drive got=%b want=000010", o);
            end
         end
         if (e > 3 + DC && e <= 16) begin
            total++;
            if (A !== 1'b0) begin
               bad++;
               $display("FAIL wq_zero e=%0d got A=%b want 0", e, A);
            end
         end
         if (e == 17) begin
            total++;
            if (A !== 1'b1) begin
               bad++;
               $display("FAIL first_pwm got A=%b want 1", A);
            end
         end
         if (e >= 17) hi += int'(A);
      end
      total++;
      if (hi != 8) begin
         bad++;
         $display("FAIL reset_duty got=%0d want=8", hi);
      end
   endtask

   task automatic test_rotation();
      logic [2:0] seq [6];
      logic [2:0] prev;
      logic [5:0] o;
      logic [5:0] ev;
      int hi;
      seq = '{3'b001, 3'b101, 3'b100, 3'b110, 3'b010, 3'b011};
      prev = 3'b101;
      for (int s = 0; s < 6; s++) begin
         @(negedge CLK);
         set_hall(seq[s]);
         ev = exp_vec(seq[s]);
         hi = 0;
         for (int e = 1; e <= 50; e++) begin
            tick();
            o = outs();
            total++;
            if (e <= 2) begin
               if ((o & ~exp_vec(prev)) !== 6'b0) begin
                  bad++;
                  $display("FAIL rot_early h=%b e=%0d got=%b",
                           seq[s], e, o);
               end
            end else if (e < 3 + DC) begin
               if (o !== 6'b0) begin
                  bad++;
                  $display("FAIL rot_dead h=%b e=%0d got=%b want=0",
                           seq[s], e, o);
               end
            end else begin
               if (((o & ~ev) !== 6'b0) || ((o[2:0] & ev[2:0])
                   !== ev[2:0])) begin
                  bad++;
                  $display("FAIL rot_drive h=%b e=%0d got=%b want=%b",
                           seq[s], e, o, ev);
               end
               if (e < 3 + DC + 16) hi += $countones(o[5:3]);
            end
         end
         total++;
         if (hi != 8) begin
            bad++;
            $display("FAIL rot_duty h=%b got=%0d want=8", seq[s], hi);
         end
         prev = seq[s];
      end
   endtask

   task automatic test_dead_reload();
      logic [5:0] o;
      @(negedge CLK);
      set_hall(3'b001);
      tick();
      @(negedge CLK);
      set_hall(3'b101);
      for (int e = 1; e <= 5; e++) begin
         tick();
         o = outs();
         total++;
         if (e == 1) begin
            if ((o & ~exp_vec(3'b011)) !== 6'b0) begin
               bad++;
               $display("FAIL reload_old got=%b", o);
            end
         end else if (e <= 4) begin
            if (o !== 6'b0) begin
               bad++;
               $display("FAIL reload_dead e=%0d got=%b want=0", e, o);
            end
         end else begin
            if (((o & ~6'b100_010) !== 6'b0) || (BB !== 1'b1)) begin
               bad++;
               $display("FAIL reload_drive got=%b want=A?BB", o);
            end
         end
      end
   endtask

   task automatic test_invalid();
      logic [2:0] codes [2];
      codes = '{3'b111, 3'b000};
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK);
         set_hall(codes[k]);
         for (int e = 1; e <= 30; e++) begin
            tick();
            if (e >= 3) begin
               total++;
               if (outs() !== 6'b0) begin
                  bad++;
                  $display("FAIL invalid h=%b e=%0d got=%b want=0",
                           codes[k], e, outs());
               end
            end
         end
      end
      @(negedge CLK);
      set_hall(3'b101);
      repeat (10) tick();
      total++;
      if (BB !== 1'b1) begin
         bad++;
         $display("FAIL invalid_recover got BB=%b want 1", BB);
      end
   endtask

   task automatic test_duty();
      int hi;
      int c;
      int wq;
      logic ea;
      logic found;
      W = 4'd0;
      repeat (40) tick();
      hi = 0;
      for (int e = 0; e < 32; e++) begin
         tick();
         hi += int'(A);
      end
      total++;
      if (hi != 0 || BB !== 1'b1) begin
         bad++;
         $display("FAIL duty0 got hi=%0d BB=%b want 0,1", hi, BB);
      end
      W = 4'd15;
      repeat (40) tick();
      hi = 0;
      for (int e = 0; e < 16; e++) begin
         tick();
         hi += int'(A);
      end
      total++;
      if (hi != 15) begin
         bad++;
         $display("FAIL duty15 got=%0d want=15", hi);
      end
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         tick();
         if (tb_cnt == 4) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL duty_phase got=timeout want=cnt4");
      end
      W = 4'd4;
      for (int j = 1; j <= 28; j++) begin
         tick();
         c  = (3 + j) % 16;
         wq = (j <= 12) ? 15 : 4;
         ea = (c < wq);
         total++;
         if (A !== ea) begin
            bad++;
            $display("FAIL duty_mid j=%0d got A=%b want %b", j, A, ea);
         end
      end
   endtask

   task automatic test_async_reset();
      @(posedge CLK);
      #5;
      total++;
      if (BB !== 1'b1) begin
         bad++;
         $display("FAIL areset_pre got BB=%b want 1", BB);
      end
      RST_N = 1'b0;
      #1;
      total++;
      if (outs() !== 6'b0) begin
         bad++;
         $display("FAIL areset got=%b want=000000", outs());
      end
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_dead_reload();
      test_invalid();
      test_duty();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
